turn_input_conditioner: RTL and testbench
=========================================

Name: turn_input_conditioner

Overview:
Front-end input stage for the tail-light sequencer.
- Synchronises and debounces the raw left and right turn switches.
- Resolves them into three mutually exclusive clean levels: left_o, right_o and haz_o.
- The downstream FSM consumes these clean levels, so it never sees metastable, bouncing or ambiguous (both-high) inputs.
- Runs on the base clock, independent of the downstream clock-enable divider.

Parameters:
SYNC_STAGES, 2, synchroniser depth per channel; legal values >= 2
DEBOUNCE_CYCLES, 1000000, consecutive base-clock cycles a synchronised input must differ from its debounced level before that level flips; legal values >= 1
CNT_W, $clog2(DEBOUNCE_CYCLES)+1, debounce counter width (derived; not overridden)

Ports:
clk  input  1  base system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
left_raw  input  1  raw left switch, asynchronous to clk
right_raw  input  1  raw right switch, asynchronous to clk
left_o  output  1  clean left request (registered)
right_o  output  1  clean right request (registered)
haz_o  output  1  clean hazard request: both switches debounced high (registered)

Behaviour:
- Reset: rst_n low asynchronously clears all synchroniser flops, debounced levels, counters and FSM states to LO. All outputs are 0 while rst_n is low and until the debounce rules below assert them.
- Reset mid-operation: any in-progress count is discarded. No output pulse or glitch is produced on release.
- Synchroniser: a SYNC_STAGES-deep flop chain per channel, giving sync_l / sync_r.
- Per-channel FSM, 4 states:
  - LO: deb=0, cnt=0. sync=1 -> CHK_HI with cnt=1, except DEBOUNCE_CYCLES=1 -> HI directly.
  - CHK_HI: sync=0 -> LO (abort, cnt=0). sync=1 and cnt==DEBOUNCE_CYCLES-1 -> HI. Otherwise cnt+1.
  - HI: deb=1. Mirror of LO: sync=0 -> CHK_LO with cnt=1, except DEBOUNCE_CYCLES=1 -> LO directly.
  - CHK_LO: mirror of CHK_HI.
- Net effect: deb flips on the DEBOUNCE_CYCLES-th consecutive cycle in which sync differs from deb. Any single disagreeing-then-agreeing cycle restarts the count from 0.
- The counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Resolution stage, registered each cycle:
  - haz_o = deb_l & deb_r
  - left_o = deb_l & ~deb_r
  - right_o = deb_r & ~deb_l
  - At most one output is high in any cycle.
- Latency: raw edge first sampled at edge 1 -> deb flips at edge SYNC_STAGES+DEBOUNCE_CYCLES -> output changes at edge SYNC_STAGES+DEBOUNCE_CYCLES+1. Rise and fall latencies are identical.
- Simultaneous events: both channels are fully independent.
  - Channels debouncing high on the same cycle -> haz_o rises directly from all-zero, with no left_o/right_o blip.
  - Staggered rises -> left_o (or right_o) for the gap, then the outputs switch to haz_o.
- Outputs are levels, not pulses. The downstream FSM samples them at its own enable rate.

Optional Feature:
Macro: TIC_GLITCH_CNT_EN
- With the macro: two extra outputs, glitch_cnt_l and glitch_cnt_r, each 8 bits.
  - Each increments by 1 whenever its channel aborts a CHK_HI or CHK_LO back to the prior stable state.
  - Saturates at 255.
  - Cleared only by rst_n.
- Without the macro: these ports and their logic do not exist. All other behaviour is identical.

Decomposition:
- Package turn_cond_pkg holds:
  - the channel state encoding: LO=2'b00, CHK_HI=2'b01, HI=2'b10, CHK_LO=2'b11
  - the glitch counter width constant (8)
- One sub-module, debounce_ch (synchroniser + FSM + counter + optional glitch counter), instantiated twice.
- The top level holds only the resolution register.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
1. left_raw 0->1 held, right_raw=0 -> left_o rises at edge 7 counting the first sampling edge as 1; right_o=haz_o=0 throughout.
2. left_raw high for 3 cycles, then low, then high and held -> no output during the short pulse; left_o rises 7 edges after the second rise. With TIC_GLITCH_CNT_EN, glitch_cnt_l=1.
3. left_raw and right_raw rise on the same cycle and are held -> haz_o rises at edge 7; left_o and right_o stay 0 on every cycle.
4. right held high (right_o=1), then left_raw rises -> right_o drops and haz_o rises on the same edge, 7 edges after left's rise; left release -> back to right_o 7 edges later.
5. rst_n pulsed low mid-CHK_HI (cnt=2) -> all outputs 0 immediately; input still high after release -> full 7-edge latency restarts from the first sampling edge.
6. DEBOUNCE_CYCLES=1 build, left_raw rise -> left_o at edge 4. With TIC_GLITCH_CNT_EN, 300 aborted glitches -> glitch_cnt reads 255.

Source files
------------

// File: rtl/turn_cond_pkg.sv
// ----------------------------------------------------------------------------
// turn_cond_pkg
// Shared definitions for the turn-switch input conditioner:
//   - ch_state_e : per-channel debounce state encoding
//   - GLITCH_W   : width of the optional per-channel glitch counters
// Optional feature macro used by the importing files: TIC_GLITCH_CNT_EN
// ----------------------------------------------------------------------------
package turn_cond_pkg;

   typedef enum logic [1:0] {
      ST_LO     = 2'b00,
      ST_CHK_HI = 2'b01,
      ST_HI     = 2'b10,
      ST_CHK_LO = 2'b11
   } ch_state_e;

   localparam int GLITCH_W = 8;

endpackage : turn_cond_pkg

// File: rtl/turn_input_conditioner_debounce_ch.sv
// ----------------------------------------------------------------------------
// debounce_ch
// One switch channel: SYNC_STAGES-deep synchroniser, 4-state debounce FSM
// and its run-length counter. The debounced level flips on the
// DEBOUNCE_CYCLES-th consecutive cycle in which the synchronised input
// differs from it.
// Optional feature (macro TIC_GLITCH_CNT_EN): saturating count of aborted
// debounce attempts.
// Ports:
//   clk          in   base clock
//   rst_n        in   asynchronous active-low reset
//   raw_i        in   raw switch, asynchronous to clk
//   deb_o        out  debounced level (decoded from the state register)
//   glitch_cnt_o out  aborted-attempt count, saturating (macro only)
// ----------------------------------------------------------------------------
module debounce_ch
   import turn_cond_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                raw_i,
   output logic                deb_o
`ifdef TIC_GLITCH_CNT_EN
   ,
   output logic [GLITCH_W-1:0] glitch_cnt_o
`endif
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   // ------------------------------------------------------------------
   // Synchroniser chain; stage 0 is the only flop that sees raw_i.
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q[0] <= 1'b0;
      end else begin
         sync_q[0] <= raw_i;
      end
   end

   generate
      for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q[gi] <= 1'b0;
            end else begin
               sync_q[gi] <= sync_q[gi-1];
            end
         end
      end
   endgenerate

   logic sync;
   assign sync = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Debounce FSM and counter
   // ------------------------------------------------------------------
   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             abort;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      abort   = 1'b0;
      unique case (state_q)
         ST_LO: begin
            cnt_d = CNT_ZERO;
            if (sync) begin
               // A one-cycle debounce skips the checking state entirely.
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = ST_HI;
               end else begin
                  state_d = ST_CHK_HI;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         ST_CHK_HI: begin
            if (!sync) begin
               state_d = ST_LO;
               cnt_d   = CNT_ZERO;
               abort   = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HI;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HI: begin
            cnt_d = CNT_ZERO;
            if (!sync) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = ST_LO;
               end else begin
                  state_d = ST_CHK_LO;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         ST_CHK_LO: begin
            if (sync) begin
               state_d = ST_HI;
               cnt_d   = CNT_ZERO;
               abort   = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LO;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_LO;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LO;
         cnt_q   <= CNT_ZERO;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // While checking a fall the level is still high, so both HI and
   // CHK_LO decode to 1.
   assign deb_o = (state_q == ST_HI) || (state_q == ST_CHK_LO);

`ifdef TIC_GLITCH_CNT_EN
   logic [GLITCH_W-1:0] glitch_q, glitch_d;

   always_comb begin
      glitch_d = glitch_q;
      if (abort && (glitch_q != {GLITCH_W{1'b1}})) begin
         glitch_d = glitch_q + GLITCH_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         glitch_q <= '0;
      end else begin
         glitch_q <= glitch_d;
      end
   end

   assign glitch_cnt_o = glitch_q;
`else
   // Abort detection only feeds the optional glitch counter.
   logic unused_abort;
   assign unused_abort = abort;
`endif

endmodule : debounce_ch

// File: rtl/turn_input_conditioner.sv
// ----------------------------------------------------------------------------
// turn_input_conditioner
// Synchronises and debounces the raw left/right turn switches and resolves
// them into three mutually exclusive registered levels.
// Optional feature macro: TIC_GLITCH_CNT_EN (adds glitch_cnt_l/glitch_cnt_r).
// Ports:
//   clk          in   base clock
//   rst_n        in   asynchronous active-low reset
//   left_raw     in   raw left switch
//   right_raw    in   raw right switch
//   left_o       out  clean left request
//   right_o      out  clean right request
//   haz_o        out  clean hazard request (both debounced high)
//   glitch_cnt_l out  left aborted-attempt count (macro only)
//   glitch_cnt_r out  right aborted-attempt count (macro only)
// ----------------------------------------------------------------------------
module turn_input_conditioner
   import turn_cond_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                left_raw,
   input  logic                right_raw,
   output logic                left_o,
   output logic                right_o,
   output logic                haz_o
`ifdef TIC_GLITCH_CNT_EN
   ,
   output logic [GLITCH_W-1:0] glitch_cnt_l,
   output logic [GLITCH_W-1:0] glitch_cnt_r
`endif
);

   logic deb_l, deb_r;

   debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_left (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw_i       (left_raw),
      .deb_o       (deb_l)
`ifdef TIC_GLITCH_CNT_EN
      ,
      .glitch_cnt_o(glitch_cnt_l)
`endif
   );

   debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_right (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw_i       (right_raw),
      .deb_o       (deb_r)
`ifdef TIC_GLITCH_CNT_EN
      ,
      .glitch_cnt_o(glitch_cnt_r)
`endif
   );

   // Resolution register: the outputs are one-hot-or-zero by construction,
   // and both channels flipping on the same edge go straight to hazard.
   logic left_q, right_q, haz_q;
   logic left_d, right_d, haz_d;

   assign haz_d   = deb_l & deb_r;
   assign left_d  = deb_l & ~deb_r;
   assign right_d = deb_r & ~deb_l;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left_q  <= 1'b0;
         right_q <= 1'b0;
         haz_q   <= 1'b0;
      end else begin
         left_q  <= left_d;
         right_q <= right_d;
         haz_q   <= haz_d;
      end
   end

   assign left_o  = left_q;
   assign right_o = right_q;
   assign haz_o   = haz_q;

endmodule : turn_input_conditioner

// File: tb/tb_turn_input_conditioner.sv
// ----------------------------------------------------------------------------
// tb_turn_input_conditioner
// Two instances share the same switch stimulus: one with DEBOUNCE_CYCLES=4,
// one with DEBOUNCE_CYCLES=1 (both SYNC_STAGES=2). A window-based model
// predicts every output on every cycle; directed checks pin exact edges.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_turn_input_conditioner;

   localparam int SS = 2;
   localparam int DA = 4;
   localparam int DB = 1;

   logic clk = 1'b0;
   logic rst_n;
   logic left_raw, right_raw;
   logic a_left, a_right, a_haz;
   logic b_left, b_right, b_haz;
`ifdef TIC_GLITCH_CNT_EN
   logic [7:0] a_gl, a_gr, b_gl, b_gr;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   turn_input_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DA)) dut (
      .clk(clk), .rst_n(rst_n), .left_raw(left_raw), .right_raw(right_raw),
      .left_o(a_left), .right_o(a_right), .haz_o(a_haz)
`ifdef TIC_GLITCH_CNT_EN
      , .glitch_cnt_l(a_gl), .glitch_cnt_r(a_gr)
`endif
   );

   turn_input_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)) dut1 (
      .clk(clk), .rst_n(rst_n), .left_raw(left_raw), .right_raw(right_raw),
      .left_o(b_left), .right_o(b_right), .haz_o(b_haz)
`ifdef TIC_GLITCH_CNT_EN
      , .glitch_cnt_l(b_gl), .glitch_cnt_r(b_gr)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Model: hist[i] holds the raw value sampled i edges ago. The debounce
   // stage at an edge sees the raw value sampled SS edges earlier, so the
   // level flips when the last D such samples all disagree with it.
   // ------------------------------------------------------------------
   function automatic bit flips(input logic [31:0] h, input bit d, input int dc);
      for (int j = 0; j < dc; j++) begin
         if (h[SS+j] == d) return 1'b0;
      end
      return 1'b1;
   endfunction

   logic [31:0] ha_l, ha_r;
   bit          da_l, da_r, db_l, db_r;
   bit          ea_left, ea_right, ea_haz, eb_left, eb_right, eb_haz;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ha_l = '0; ha_r = '0;
         da_l = 0; da_r = 0; db_l = 0; db_r = 0;
         ea_left = 0; ea_right = 0; ea_haz = 0;
         eb_left = 0; eb_right = 0; eb_haz = 0;
      end else begin
         // outputs registered from the levels held before this edge
         ea_haz = da_l & da_r; ea_left = da_l & ~da_r; ea_right = da_r & ~da_l;
         eb_haz = db_l & db_r; eb_left = db_l & ~db_r; eb_right = db_r & ~db_l;
         ha_l = {ha_l[30:0], left_raw};
         ha_r = {ha_r[30:0], right_raw};
         if (flips(ha_l, da_l, DA)) da_l = ~da_l;
         if (flips(ha_r, da_r, DA)) da_r = ~da_r;
         if (flips(ha_l, db_l, DB)) db_l = ~db_l;
         if (flips(ha_r, db_r, DB)) db_r = ~db_r;
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      check("a_left",  {31'b0, a_left},  {31'b0, ea_left});
      check("a_right", {31'b0, a_right}, {31'b0, ea_right});
      check("a_haz",   {31'b0, a_haz},   {31'b0, ea_haz});
      check("b_left",  {31'b0, b_left},  {31'b0, eb_left});
      check("b_right", {31'b0, b_right}, {31'b0, eb_right});
      check("b_haz",   {31'b0, b_haz},   {31'b0, eb_haz});
      check("a_onehot", {31'b0, (32'(a_left) + 32'(a_right) + 32'(a_haz)) <= 1}, 32'd1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; left_raw = 1'b0; right_raw = 1'b0;
      tick(3);
      check("rst_left",  {31'b0, a_left},  32'd0);
      check("rst_right", {31'b0, a_right}, 32'd0);
      check("rst_haz",   {31'b0, a_haz},   32'd0);
      rst_n = 1'b1;
      tick(2);

      // 1: left rise; D=4 at edge 7, D=1 at edge 4
      left_raw = 1'b1;
      tick(3); check("t1_b_e3", {31'b0, b_left}, 32'd0);
      tick(1); check("t1_b_e4", {31'b0, b_left}, 32'd1);
      tick(2); check("t1_a_e6", {31'b0, a_left}, 32'd0);
      tick(1); check("t1_a_e7", {31'b0, a_left}, 32'd1);
      left_raw = 1'b0;
      tick(6); check("t1_fall_e6", {31'b0, a_left}, 32'd1);
      tick(1); check("t1_fall_e7", {31'b0, a_left}, 32'd0);
      tick(4);

      // 2: 3-cycle pulse aborts, then a held rise
      left_raw = 1'b1; tick(3);
      left_raw = 1'b0; tick(1);
      left_raw = 1'b1;
      tick(6); check("t2_e6", {31'b0, a_left}, 32'd0);
      tick(1); check("t2_e7", {31'b0, a_left}, 32'd1);
`ifdef TIC_GLITCH_CNT_EN
      check("t2_glitch_l", {24'b0, a_gl}, 32'd1);
      check("t2_glitch_r", {24'b0, a_gr}, 32'd0);
`endif
      left_raw = 1'b0; tick(10);

      // 3: simultaneous rise goes straight to hazard
      left_raw = 1'b1; right_raw = 1'b1;
      tick(6); check("t3_e6", {31'b0, a_haz}, 32'd0);
      tick(1); check("t3_e7", {31'b0, a_haz}, 32'd1);
      left_raw = 1'b0; right_raw = 1'b0; tick(10);

      // 4: right held, left joins then leaves
      right_raw = 1'b1; tick(10);
      check("t4_right", {31'b0, a_right}, 32'd1);
      left_raw = 1'b1;
      tick(6); check("t4_e6_r", {31'b0, a_right}, 32'd1);
      tick(1); check("t4_e7_r", {31'b0, a_right}, 32'd0);
      check("t4_e7_h", {31'b0, a_haz}, 32'd1);
      left_raw = 1'b0;
      tick(6); check("t4_rel_e6", {31'b0, a_haz}, 32'd1);
      tick(1); check("t4_rel_e7", {31'b0, a_right}, 32'd1);
      check("t4_rel_h", {31'b0, a_haz}, 32'd0);

      // 5: reset while right_o high and left mid-count (cnt=2)
      left_raw = 1'b1;
      tick(4);
      rst_n = 1'b0;
      #1;
      check("t5_async_r", {31'b0, a_right}, 32'd0);
      check("t5_async_h", {31'b0, a_haz},   32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(6); check("t5_e6_h", {31'b0, a_haz}, 32'd0);
      check("t5_e6_r", {31'b0, a_right}, 32'd0);
      tick(1); check("t5_e7_h", {31'b0, a_haz}, 32'd1);
      left_raw = 1'b0; right_raw = 1'b0; tick(10);

      // 6: 300 one-cycle glitches on left
      for (int i = 0; i < 300; i++) begin
         left_raw = 1'b1; tick(1);
         left_raw = 1'b0; tick(3);
      end
      tick(4);
      check("t6_a_left", {31'b0, a_left}, 32'd0);
`ifdef TIC_GLITCH_CNT_EN
      check("t6_glitch_sat", {24'b0, a_gl}, 32'd255);
      check("t6_glitch_b",   {24'b0, b_gl}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_turn_input_conditioner
